i2c_slave_tx_shifter: RTL and testbench
=======================================

// Module: i2c_slave_tx_shifter
// PURPOSE
//   Transmit data source for the I2C slave byte writer. Buffers bytes from the
//   user side in a small FIFO and presents them MSB-first on a single 'data'
//   bit. Advances one bit per 'load' pulse from the byte writer. Sits directly
//   upstream of the slave write-byte stage: data -> its 'data' input, its
//   'load'/'finish' -> this block.
// PARAMETERS
//   DEPTH      2      FIFO entries (bytes); legal range 1..16
//   FILL_BYTE  8'hFF  byte sent when a byte is started with the FIFO empty
// PORTS
//   clock      in   1      system clock; all logic on rising edge
//   reset      in   1      synchronous, active-high reset
//   tx_data    in   8      byte from user logic
//   tx_valid   in   1      tx_data valid
//   tx_ready   out  1      FIFO can accept; push = tx_valid && tx_ready
//   start      in   1      1-cycle pulse from slave controller: new byte begins
//   load       in   1      1-cycle pulse from byte writer: current bit done
//   finish     in   1      1-cycle pulse from byte writer: 8th bit done
//   flush      in   1      1-cycle pulse: STOP/NACK seen, discard all data
//   data       out  1      current bit for the bus (shreg[7])
//   busy       out  1      byte in flight (between start and 8th load)
//   byte_sent  out  1      1-cycle pulse, cycle after the 8th load
//   underrun   out  1      1-cycle pulse, start accepted with FIFO empty
//   proto_err  out  1      1-cycle pulse, illegal start/load (see below)
//   level      out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//   Reset: FIFO empty, level=0, tx_ready=1, shreg=8'hFF (data=1, SDA released),
//     bit_cnt=0, busy=0, all pulse outputs 0.
//   FIFO: circular, rd/wr pointers wrap at DEPTH-1 -> 0. tx_ready = (level != DEPTH).
//     Push and pop in the same cycle: level unchanged. This holds when full
//     only if the pop is registered first; push is gated by the registered
//     tx_ready, so no push is accepted while full.
//   Two states: IDLE (busy=0), SHIFT (busy=1).
//   IDLE + start: if level>0, pop head into shreg. Otherwise load FILL_BYTE
//     into shreg and pulse underrun next cycle. Then bit_cnt=0 and -> SHIFT.
//     data reflects the new MSB the cycle after start (latency 1).
//   SHIFT + load: shreg <= {shreg[6:0],1'b1}; bit_cnt++.
//     On the 8th load (bit_cnt==7): -> IDLE, bit_cnt=0, byte_sent pulses
//     next cycle. shreg now = 8'hFF, so data returns to 1.
//   finish: used as a cross-check only. If finish pulses with a load that is
//     not the 8th, assert proto_err. The state is still advanced by load alone.
//   IDLE + load: ignored; proto_err pulses.
//   SHIFT + start: ignored (the byte in flight continues); proto_err pulses.
//   start and load in the same cycle: in IDLE, start wins and load is ignored
//     with no error. In SHIFT, load is processed and start is flagged as above.
//   flush: highest priority. It empties the FIFO, sets shreg=8'hFF, bit_cnt=0,
//     -> IDLE. Any push in the same cycle is dropped, and no byte_sent pulses.
//   reset mid-byte: same end state as the reset values above, next cycle.
//   data changes only in the cycle after start/load/flush/reset. It is stable
//     while the byte writer samples it.
// TESTING
//   T1 push 8'hA5, start, 8 loads (finish with 8th) -> data seq 1,0,1,0,0,1,0,1;
//      byte_sent 1 cycle after 8th load; then data=1, busy=0, level=0.
//   T2 DEPTH=2: push 3 bytes back-to-back -> tx_ready=0 after 2nd, 3rd held
//      until start pops; then level=2 with all bytes sent in order.
//   T3 start with FIFO empty -> underrun pulse, bits of 8'hFF sent, level stays 0.
//   T4 push and start in the same cycle, level=1 -> level stays 1, head byte
//      shifted, new byte stays queued.
//   T5 flush after 3 loads with level=2 -> data=1, busy=0, level=0,
//      tx_ready=1, no byte_sent.
//   T6 load in IDLE, then start during SHIFT, then finish on 5th load ->
//      proto_err pulse each time; the byte still completes on the 8th load.

Source files
------------

// File: rtl/i2c_slave_tx_shifter_if.sv
// Signal bundle between user logic, the slave byte writer and the tx shifter.
// master = user/byte-writer side, slave = the shifter itself.
interface i2c_slave_tx_shifter_if #(
   parameter int unsigned DEPTH = 2
) ();
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          start;
   logic          load;
   logic          finish;
   logic          flush;
   logic          data;
   logic          busy;
   logic          byte_sent;
   logic          underrun;
   logic          proto_err;
   logic [LW-1:0] level;

   modport master (
      output tx_data, tx_valid, start, load, finish, flush,
      input  tx_ready, data, busy, byte_sent, underrun, proto_err, level
   );

   modport slave (
      input  tx_data, tx_valid, start, load, finish, flush,
      output tx_ready, data, busy, byte_sent, underrun, proto_err, level
   );
endinterface

// File: rtl/i2c_slave_tx_shifter.sv
// Byte FIFO feeding an MSB-first shift register, advanced one bit per load pulse
// from the slave byte writer; idle/flushed output is 1 so SDA stays released.
module i2c_slave_tx_shifter #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
   input logic                   clock,
   input logic                   reset,
   i2c_slave_tx_shifter_if.slave bus
);
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {StIdle, StShift} state_e;

   state_e        state_q;
   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [7:0]    shreg_q;
   logic [2:0]    bit_cnt_q;
   logic          byte_sent_q;
   logic          underrun_q;
   logic          proto_err_q;
   logic          tx_ready;
   logic          push;
   logic          pop;

   // tx_ready derives from the registered level, so a full FIFO never accepts a push.
   assign tx_ready = (level_q != LW'(DEPTH));
   assign push     = bus.tx_valid && tx_ready && !bus.flush;
   assign pop      = (state_q == StIdle) && bus.start && (level_q != '0) && !bus.flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         shreg_q     <= 8'hFF;
         bit_cnt_q   <= '0;
         byte_sent_q <= 1'b0;
         underrun_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         byte_sent_q <= 1'b0;
         underrun_q  <= 1'b0;
         proto_err_q <= 1'b0;
         if (bus.flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            shreg_q   <= 8'hFF;
            bit_cnt_q <= '0;
            state_q   <= StIdle;
         end else begin
            if (push) begin
               mem_q[wr_ptr_q] <= bus.tx_data;
               wr_ptr_q        <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
               2'b10:   level_q <= level_q + 1'b1;
               2'b01:   level_q <= level_q - 1'b1;
               default: level_q <= level_q;
            endcase

            case (state_q)
               StIdle: begin
                  // start beats a coincident load here; that load is not an error.
                  if (bus.start) begin
                     shreg_q    <= (level_q != '0) ? mem_q[rd_ptr_q] : FILL_BYTE;
                     underrun_q <= (level_q == '0);
                     bit_cnt_q  <= '0;
                     state_q    <= StShift;
                  end else if (bus.load) begin
                     proto_err_q <= 1'b1;
                  end
               end
               StShift: begin
                  if (bus.start) begin
                     proto_err_q <= 1'b1;
                  end
                  if (bus.load) begin
                     shreg_q <= {shreg_q[6:0], 1'b1};
                     if (bit_cnt_q == 3'd7) begin
                        bit_cnt_q   <= '0;
                        byte_sent_q <= 1'b1;
                        state_q     <= StIdle;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bus.finish) begin
                           proto_err_q <= 1'b1;
                        end
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.tx_ready  = tx_ready;
   assign bus.data      = shreg_q[7];
   assign bus.busy      = (state_q == StShift);
   assign bus.byte_sent = byte_sent_q;
   assign bus.underrun  = underrun_q;
   assign bus.proto_err = proto_err_q;
   assign bus.level     = level_q;
endmodule

// File: tb/tb_i2c_slave_tx_shifter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the tx shifter.
module tb_i2c_slave_tx_shifter;
   localparam int unsigned DEPTH = 2;
   localparam logic [7:0]  FILL  = 8'hFF;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   i2c_slave_tx_shifter_if #(.DEPTH(DEPTH)) bus ();

   i2c_slave_tx_shifter #(
      .DEPTH    (DEPTH),
      .FILL_BYTE(FILL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // Model state: queued bytes, byte in flight and how many bits of it are done.
   logic [7:0] m_q[$];
   logic [7:0] m_cur   = 8'hFF;
   int         m_nbits = 0;
   bit         m_busy  = 1'b0;
   bit         m_sent  = 1'b0;
   bit         m_under = 1'b0;
   bit         m_err   = 1'b0;
   bit         m_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit push;
      m_sent  = 1'b0;
      m_under = 1'b0;
      m_err   = 1'b0;
      if (reset) begin
         m_q.delete();
         m_busy  = 1'b0;
         m_nbits = 0;
         m_valid = 1'b1;
      end else if (bus.flush) begin
         m_q.delete();
         m_busy  = 1'b0;
         m_nbits = 0;
      end else begin
         push = bus.tx_valid && (m_q.size() < DEPTH);
         if (!m_busy) begin
            if (bus.start) begin
               if (m_q.size() > 0) begin
                  m_cur = m_q.pop_front();
               end else begin
                  m_cur   = FILL;
                  m_under = 1'b1;
               end
               m_busy  = 1'b1;
               m_nbits = 0;
            end else if (bus.load) begin
               m_err = 1'b1;
            end
         end else begin
            if (bus.start) m_err = 1'b1;
            if (bus.load) begin
               m_nbits++;
               if (m_nbits == 8) begin
                  m_busy  = 1'b0;
                  m_nbits = 0;
                  m_sent  = 1'b1;
               end else if (bus.finish) begin
                  m_err = 1'b1;
               end
            end
         end
         if (push) m_q.push_back(bus.tx_data);
      end
   endtask

   // Outputs here reflect the last rising edge; inputs are those the next edge samples.
   always @(negedge clock) begin
      if (m_valid) begin
         chk("m_data", bus.data, m_busy ? m_cur[7 - m_nbits] : 1'b1);
         chk("m_busy", bus.busy, m_busy);
         chk("m_byte_sent", bus.byte_sent, m_sent);
         chk("m_underrun", bus.underrun, m_under);
         chk("m_proto_err", bus.proto_err, m_err);
         chk("m_level", bus.level, m_q.size());
         chk("m_tx_ready", bus.tx_ready, m_q.size() != DEPTH);
      end
      model_step();
   end

   task automatic step();
      @(posedge clock);
      #1;
      bus.start    = 1'b0;
      bus.load     = 1'b0;
      bus.finish   = 1'b0;
      bus.flush    = 1'b0;
      bus.tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      step();
   endtask

   task automatic shift_byte(input bit fin8, output logic [7:0] got);
      for (int i = 0; i < 8; i++) begin
         got[7-i]   = bus.data;
         bus.load   = 1'b1;
         bus.finish = fin8 && (i == 7);
         step();
      end
   endtask

   task automatic send_byte(input bit fin8, output logic [7:0] got);
      bus.start = 1'b1;
      step();
      shift_byte(fin8, got);
   endtask

   logic [7:0] got;

   initial begin
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      bus.start    = 1'b0;
      bus.load     = 1'b0;
      bus.finish   = 1'b0;
      bus.flush    = 1'b0;
      do_reset();
      chk("rst_data", bus.data, 1'b1);
      chk("rst_level", bus.level, 0);
      chk("rst_tx_ready", bus.tx_ready, 1'b1);

      // T1: A5 goes out 1,0,1,0,0,1,0,1.
      push_byte(8'hA5);
      send_byte(1'b1, got);
      chk("t1_bits", got, 8'hA5);
      chk("t1_byte_sent", bus.byte_sent, 1'b1);
      chk("t1_data_idle", bus.data, 1'b1);
      chk("t1_busy", bus.busy, 1'b0);
      chk("t1_level", bus.level, 0);
      step();
      chk("t1_sent_once", bus.byte_sent, 1'b0);

      // T2: third byte held off while full.
      do_reset();
      push_byte(8'h11);
      push_byte(8'h22);
      chk("t2_full_ready", bus.tx_ready, 1'b0);
      push_byte(8'h33);
      chk("t2_full_level", bus.level, 2);
      bus.tx_data  = 8'h33;
      bus.tx_valid = 1'b1;
      bus.start    = 1'b1;
      step();
      chk("t2_pop_level", bus.level, 1);
      push_byte(8'h33);
      chk("t2_refill_level", bus.level, 2);
      shift_byte(1'b1, got);
      chk("t2_byte0", got, 8'h11);
      send_byte(1'b1, got);
      chk("t2_byte1", got, 8'h22);
      send_byte(1'b1, got);
      chk("t2_byte2", got, 8'h33);
      chk("t2_level_end", bus.level, 0);

      // T3: underrun sends the fill byte.
      do_reset();
      bus.start = 1'b1;
      step();
      chk("t3_underrun", bus.underrun, 1'b1);
      shift_byte(1'b1, got);
      chk("t3_bits", got, FILL);
      chk("t3_level", bus.level, 0);

      // T4: push and start together.
      do_reset();
      push_byte(8'h44);
      bus.tx_data  = 8'h55;
      bus.tx_valid = 1'b1;
      bus.start    = 1'b1;
      step();
      chk("t4_level", bus.level, 1);
      shift_byte(1'b1, got);
      chk("t4_head", got, 8'h44);
      send_byte(1'b1, got);
      chk("t4_queued", got, 8'h55);

      // T5: flush mid-byte.
      do_reset();
      push_byte(8'h66);
      push_byte(8'h77);
      bus.start = 1'b1;
      step();
      push_byte(8'h88);
      for (int i = 0; i < 3; i++) begin
         bus.load = 1'b1;
         step();
      end
      chk("t5_level_pre", bus.level, 2);
      bus.flush    = 1'b1;
      bus.tx_valid = 1'b1;
      step();
      chk("t5_data", bus.data, 1'b1);
      chk("t5_busy", bus.busy, 1'b0);
      chk("t5_level", bus.level, 0);
      chk("t5_tx_ready", bus.tx_ready, 1'b1);
      chk("t5_no_sent", bus.byte_sent, 1'b0);

      // T6: protocol errors do not derail the byte.
      do_reset();
      push_byte(8'h99);
      bus.load = 1'b1;
      step();
      chk("t6_idle_load_err", bus.proto_err, 1'b1);
      chk("t6_idle_load_busy", bus.busy, 1'b0);
      bus.start = 1'b1;
      step();
      chk("t6_start_ok", bus.proto_err, 1'b0);
      for (int i = 0; i < 8; i++) begin
         got[7-i]   = bus.data;
         bus.load   = 1'b1;
         bus.start  = (i == 2);
         bus.finish = (i == 4);
         step();
         chk("t6_err_pulse", bus.proto_err, (i == 2) || (i == 4));
      end
      chk("t6_bits", got, 8'h99);
      chk("t6_byte_sent", bus.byte_sent, 1'b1);

      // Randomized traffic, checked by the per-cycle model.
      for (int c = 0; c < 4000; c++) begin
         bus.tx_valid = ($urandom_range(0, 1) == 1);
         bus.tx_data  = 8'($urandom);
         bus.start    = ($urandom_range(0, 9) == 0);
         bus.load     = ($urandom_range(0, 2) == 0);
         bus.finish   = bus.load && ($urandom_range(0, 7) == 0);
         bus.flush    = ($urandom_range(0, 149) == 0);
         reset        = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
